// File: rtl/axi2ahb_ahb_ctrl.sv
// AHB-Lite master sequencer: issues one AHB burst per command FIFO entry,
// gates on buffer space, and turns AHB errors into per-beat error responses.
module axi2ahb_ahb_ctrl #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_empty,
    input  logic                 cmd_read,
    input  logic [ID_BITS-1:0]   cmd_id,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [3:0]           cmd_len,
    input  logic [1:0]           cmd_size,
    input  logic                 cmd_err,
    output logic                 ahb_finish,
    output logic [ID_BITS-1:0]   cur_id,
    input  logic [4:0]           wbeats_avail,
    input  logic [4:0]           rbeats_space,
    output logic                 wdata_pop,
    output logic                 rdata_push,
    output logic                 data_last,
    output logic                 data_err,
    output logic [ADDR_BITS-1:0] HADDR,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HBURST,
    output logic [2:0]           HSIZE,
    output logic                 HWRITE,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, FLUSH, DONE} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] haddr_nxt, haddr_inc, step;
    logic [1:0]           htrans_nxt;
    logic [2:0]           hburst_nxt, hsize_nxt, burst_code;
    logic                 hwrite_nxt;
    logic [ID_BITS-1:0]   cur_id_nxt;
    logic [3:0]           len_q, len_nxt;
    logic                 rd_q, rd_nxt;
    logic [3:0]           a_cnt, a_cnt_nxt;
    logic [3:0]           d_cnt, d_cnt_nxt;
    logic [4:0]           rem, rem_nxt;
    logic                 dph, dph_nxt;
    logic                 err_q, err_nxt;

    logic [4:0]  beats;
    logic [11:0] burst_bytes;
    logic        gate, crosses, in_burst, accept, beat_ok, err_start, beat_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            HADDR  <= '0;
            HTRANS <= TR_IDLE;
            HBURST <= 3'b000;
            HSIZE  <= 3'b000;
            HWRITE <= 1'b0;
            cur_id <= '0;
            len_q  <= 4'd0;
            rd_q   <= 1'b0;
            a_cnt  <= 4'd0;
            d_cnt  <= 4'd0;
            rem    <= 5'd0;
            dph    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            HADDR  <= haddr_nxt;
            HTRANS <= htrans_nxt;
            HBURST <= hburst_nxt;
            HSIZE  <= hsize_nxt;
            HWRITE <= hwrite_nxt;
            cur_id <= cur_id_nxt;
            len_q  <= len_nxt;
            rd_q   <= rd_nxt;
            a_cnt  <= a_cnt_nxt;
            d_cnt  <= d_cnt_nxt;
            rem    <= rem_nxt;
            dph    <= dph_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        haddr_nxt  = HADDR;
        htrans_nxt = HTRANS;
        hburst_nxt = HBURST;
        hsize_nxt  = HSIZE;
        hwrite_nxt = HWRITE;
        cur_id_nxt = cur_id;
        len_nxt    = len_q;
        rd_nxt     = rd_q;
        a_cnt_nxt  = a_cnt;
        d_cnt_nxt  = d_cnt;
        rem_nxt    = rem;
        dph_nxt    = dph;
        err_nxt    = err_q;

        beats       = {1'b0, cmd_len} + 5'd1;
        gate        = cmd_read ? (rbeats_space >= beats) : (wbeats_avail >= beats);
        burst_bytes = {7'd0, beats} << cmd_size;
        // A burst that would run past a 1 KB boundary is issued as INCR.
        crosses     = ({2'd0, cmd_addr[9:0]} + burst_bytes) > 12'd1024;
        case (cmd_len)
            4'd3:    burst_code = 3'b011;
            4'd7:    burst_code = 3'b101;
            4'd15:   burst_code = 3'b111;
            default: burst_code = 3'b000;
        endcase

        step      = {{(ADDR_BITS-1){1'b0}}, 1'b1} << HSIZE[1:0];
        haddr_inc = HADDR + step;
        in_burst  = (state == ADDR) || (state == DATA);
        accept    = (state == ADDR) && HTRANS[1] && HREADY;
        beat_ok   = in_burst && dph && HREADY;
        err_start = in_burst && dph && HRESP && !HREADY && !err_q;
        beat_done = beat_ok || (state == FLUSH);

        ahb_finish = (state == DONE);
        wdata_pop  = beat_done && !rd_q;
        rdata_push = beat_done && rd_q;
        data_last  = beat_done && ((state == FLUSH) ? (rem == 5'd1) : (d_cnt == len_q));
        data_err   = beat_done && ((state == FLUSH) || err_q);

        case (state)
            IDLE: begin
                if (!cmd_empty && gate) begin
                    cur_id_nxt = cmd_id;
                    len_nxt    = cmd_len;
                    rd_nxt     = cmd_read;
                    a_cnt_nxt  = 4'd0;
                    d_cnt_nxt  = 4'd0;
                    dph_nxt    = 1'b0;
                    err_nxt    = 1'b0;
                    if (cmd_err) begin
                        rem_nxt   = beats;
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt  = ADDR;
                        haddr_nxt  = cmd_addr;
                        htrans_nxt = TR_NONSEQ;
                        hsize_nxt  = {1'b0, cmd_size};
                        hwrite_nxt = ~cmd_read;
                        hburst_nxt = crosses ? 3'b001 : burst_code;
                    end
                end
            end
            ADDR, DATA: begin
                if (accept) begin
                    dph_nxt   = 1'b1;
                    haddr_nxt = haddr_inc;
                    a_cnt_nxt = a_cnt + 4'd1;
                    if (a_cnt == len_q) begin
                        htrans_nxt = TR_IDLE;
                        state_nxt  = DATA;
                    end else begin
                        htrans_nxt = (haddr_inc[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                    end
                end else if (HREADY) begin
                    dph_nxt = 1'b0;
                end
                // First ERROR cycle: withdraw any pending address phase.
                if (err_start) begin
                    err_nxt    = 1'b1;
                    htrans_nxt = TR_IDLE;
                end
                if (beat_ok) begin
                    d_cnt_nxt = d_cnt + 4'd1;
                    if (d_cnt == len_q) begin
                        err_nxt   = 1'b0;
                        state_nxt = DONE;
                    end else if (err_q) begin
                        err_nxt   = 1'b0;
                        rem_nxt   = {1'b0, len_q} - {1'b0, d_cnt};
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                rem_nxt = rem - 5'd1;
                if (rem == 5'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi2ahb_ahb_ctrl.sv
// Directed bench for axi2ahb_ahb_ctrl: cycle-vector tables for the main
// burst/error/flush cases plus hand sequences for 1 KB crossing and reset.
module tb_axi2ahb_ahb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_empty, cmd_read, cmd_err;
    logic [3:0]  cmd_id, cmd_len;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic        ahb_finish;
    logic [3:0]  cur_id;
    logic [4:0]  wbeats_avail, rbeats_space;
    logic        wdata_pop, rdata_push, data_last, data_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic        HWRITE, HREADY, HRESP;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        hready;
        logic        hresp;
        logic [4:0]  wav;
        logic [4:0]  rsp;
        logic [1:0]  trans;
        logic        chk_addr;
        logic [31:0] addr;
        logic [3:0]  dflags;
        logic        fin;
        logic        chk_ctl;
        logic [6:0]  ctl;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    axi2ahb_ahb_ctrl #(.ID_BITS(4), .ADDR_BITS(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_empty(cmd_empty), .cmd_read(cmd_read), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_err(cmd_err),
        .ahb_finish(ahb_finish), .cur_id(cur_id),
        .wbeats_avail(wbeats_avail), .rbeats_space(rbeats_space),
        .wdata_pop(wdata_pop), .rdata_push(rdata_push),
        .data_last(data_last), .data_err(data_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    function automatic vec_t mk(logic hready, logic hresp, logic [4:0] wav, logic [4:0] rsp,
                                logic [1:0] trans, logic chk_addr, logic [31:0] addr,
                                logic [3:0] dflags, logic fin, logic chk_ctl, logic [6:0] ctl);
        vec_t v;
        v.hready = hready;  v.hresp = hresp;  v.wav = wav;  v.rsp = rsp;
        v.trans = trans;    v.chk_addr = chk_addr;  v.addr = addr;
        v.dflags = dflags;  v.fin = fin;  v.chk_ctl = chk_ctl;  v.ctl = ctl;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic rd, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] size, input logic err);
        cmd_read  = rd;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_err   = err;
        cmd_empty = 1'b0;
    endtask

    // Row i of the table is cycle c(i); the FIFO pops after the finish cycle.
    task automatic apply_stimulus(input string tag);
        vec_t v;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            HREADY       = v.hready;
            HRESP        = v.hresp;
            wbeats_avail = v.wav;
            rbeats_space = v.rsp;
            @(negedge clk);
            check_output($sformatf("%s c%0d trans/pop/push/last/err/fin", tag, i),
                         {HTRANS, wdata_pop, rdata_push, data_last, data_err, ahb_finish},
                         {v.trans, v.dflags, v.fin});
            if (v.chk_addr)
                check_output($sformatf("%s c%0d haddr", tag, i), HADDR, v.addr);
            if (v.chk_ctl)
                check_output($sformatf("%s c%0d burst/size/write", tag, i),
                             {HBURST, HSIZE, HWRITE}, v.ctl);
            step();
            if (v.fin) cmd_empty = 1'b1;
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pops;
        int fin_cyc;

        reset = 1'b0;  cmd_empty = 1'b1;  cmd_read = 1'b0;  cmd_err = 1'b0;
        cmd_id = 4'd0; cmd_addr = 32'd0;  cmd_len = 4'd0;   cmd_size = 2'd0;
        wbeats_avail = 5'd0;  rbeats_space = 5'd0;  HREADY = 1'b1;  HRESP = 1'b0;

        #12;
        check_output("reset ctl/data outputs",
                     {HTRANS, HBURST, HSIZE, HWRITE, ahb_finish, wdata_pop, rdata_push, data_last, data_err},
                     '0);
        check_output("reset haddr", HADDR, 32'd0);
        check_output("reset cur_id", cur_id, 4'd0);
        step();
        reset = 1'b1;
        step();

        // Write INCR4 at 0x100, zero wait states
        set_cmd(1'b0, 4'h1, 32'h100, 4'd3, 2'd2, 1'b0);
        vecs.push_back(mk(1, 0, 4, 0, 2'b00, 0, 0,        4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4, 0, 2'b10, 1, 32'h100,  4'b0000, 0, 1, 7'b011_010_1));
        vecs.push_back(mk(1, 0, 4, 0, 2'b11, 1, 32'h104,  4'b1000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4, 0, 2'b11, 1, 32'h108,  4'b1000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4, 0, 2'b11, 1, 32'h10C,  4'b1000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4, 0, 2'b00, 0, 0,        4'b1010, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4, 0, 2'b00, 0, 0,        4'b0000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4, 0, 2'b00, 0, 0,        4'b0000, 0, 0, 0));
        apply_stimulus("wr_incr4");

        // Read SINGLE held off by an empty read buffer for five cycles
        set_cmd(1'b1, 4'h3, 32'h40, 4'd0, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0,       4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2'b10, 1, 32'h40,  4'b0000, 0, 1, 7'b000_010_0));
        vecs.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0,       4'b0110, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0,       4'b0000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0,       4'b0000, 0, 0, 0));
        apply_stimulus("rd_gated");

        // Write INCR8 with an ERROR response on beat 2
        set_cmd(1'b0, 4'h7, 32'h200, 4'd7, 2'd2, 1'b0);
        vecs.push_back(mk(1, 0, 8, 0, 2'b00, 0, 0,       4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8, 0, 2'b10, 1, 32'h200, 4'b0000, 0, 1, 7'b101_010_1));
        vecs.push_back(mk(1, 0, 8, 0, 2'b11, 1, 32'h204, 4'b1000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8, 0, 2'b11, 1, 32'h208, 4'b1000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8, 0, 2'b11, 1, 32'h20C, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8, 0, 2'b00, 0, 0,       4'b1001, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 8, 0, 2'b00, 0, 0,   4'b1001, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8, 0, 2'b00, 0, 0,       4'b1011, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8, 0, 2'b00, 0, 0,       4'b0000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 8, 0, 2'b00, 0, 0,       4'b0000, 0, 0, 0));
        apply_stimulus("wr_error");

        // Illegal read command of four beats: flushed without AHB traffic
        set_cmd(1'b1, 4'h9, 32'h500, 4'd3, 2'd2, 1'b1);
        vecs.push_back(mk(1, 0, 0, 4, 2'b00, 0, 0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 0, 4, 2'b00, 0, 0, 4'b0101, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4, 2'b00, 0, 0, 4'b0111, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4, 2'b00, 0, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4, 2'b00, 0, 0, 4'b0000, 0, 0, 0));
        apply_stimulus("cmd_err");

        // Read INCR16 of doublewords crossing 0x400
        set_cmd(1'b1, 4'h5, 32'h3C0, 4'd15, 2'd3, 1'b0);
        rbeats_space = 5'd16;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        @(negedge clk);
        check_output("x1k c0 trans", HTRANS, 2'b00);
        for (int k = 0; k < 16; k++) begin
            step();
            @(negedge clk);
            check_output($sformatf("x1k beat%0d trans", k), HTRANS,
                         (k == 0 || k == 8) ? 2'b10 : 2'b11);
            check_output($sformatf("x1k beat%0d haddr", k), HADDR, 32'h3C0 + 8 * k);
            check_output($sformatf("x1k c%0d push/last", k + 1), {rdata_push, data_last},
                         (k > 0) ? 2'b10 : 2'b00);
            if (k == 0) check_output("x1k hburst", HBURST, 3'b001);
        end
        step();
        @(negedge clk);
        check_output("x1k last beat", {HTRANS, rdata_push, data_last, data_err, ahb_finish}, 6'b00_1100);
        step();
        @(negedge clk);
        check_output("x1k finish", {rdata_push, ahb_finish}, 2'b01);
        step();
        cmd_empty = 1'b1;
        step();

        // Reset during the third beat of an INCR8 write, then restart
        set_cmd(1'b0, 4'hA, 32'h300, 4'd7, 2'd2, 1'b0);
        wbeats_avail = 5'd8;
        @(negedge clk);
        step();
        @(negedge clk);
        check_output("rst c1 trans/addr", {HTRANS, HADDR}, {2'b10, 32'h300});
        check_output("rst c1 cur_id", cur_id, 4'hA);
        step();
        step();
        @(negedge clk);
        check_output("rst c3 trans/addr", {HTRANS, HADDR}, {2'b11, 32'h308});
        #2;
        reset = 1'b0;
        #1;
        check_output("rst async ctl/data outputs",
                     {HTRANS, HBURST, HSIZE, HWRITE, ahb_finish, wdata_pop, rdata_push, data_last, data_err},
                     '0);
        check_output("rst async haddr/cur_id", {HADDR, cur_id}, 36'd0);
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        check_output("rst restart c0", {HTRANS, ahb_finish}, 3'b000);
        step();
        @(negedge clk);
        check_output("rst restart c1 trans/addr", {HTRANS, HADDR}, {2'b10, 32'h300});
        pops    = 0;
        fin_cyc = -1;
        for (int c = 2; c <= 30; c++) begin
            step();
            @(negedge clk);
            if (wdata_pop) pops++;
            if (ahb_finish) begin
                fin_cyc = c;
                break;
            end
        end
        check_output("rst restart finish cycle", fin_cyc, 10);
        check_output("rst restart pop count", pops, 8);
        step();
        cmd_empty = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
